// File: rtl/sha_pkg.sv
// Shared definitions for the SHA work controller.
//   - sha_state_e : controller FSM state encoding (also exported on the
//                   debug state output of sha_work_ctrl)
//   - STATUS_*    : status byte values sent as the first response byte
//   - WORK_BYTES  : number of host bytes in one work unit
//   - PAD_WORD4 / LEN_WORD15 : fixed SHA-256 padding words of the
//                   second header block
package sha_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SOLVE = 3'd3,
        ST_RESP  = 3'd4
    } sha_state_e;

    localparam logic [7:0]  STATUS_FOUND   = 8'h01;
    localparam logic [7:0]  STATUS_TIMEOUT = 8'h02;
    localparam int          WORK_BYTES     = 44;
    localparam int          RESP_BYTES     = 5;
    localparam logic [31:0] PAD_WORD4      = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD15     = 32'h0000_0280;

endpackage : sha_pkg

// File: rtl/sha_work_ctrl_if.sv
// Bundle of the host byte link and the SHA-core control bus.
// Host side : rx_data/rx_valid (no backpressure), tx_data/tx_valid/tx_ready.
// Core side : midState, headData, loadState, solveEn, flag, goldenNonce.
// Handshake: a tx byte transfers on a rising clk edge where tx_valid and
// tx_ready are both high; while tx_valid is high and tx_ready is low,
// tx_data is held unchanged. rx bytes are taken on any edge with rx_valid
// high and cannot be refused.
// Modports: master = the controller, slave = host + SHA core environment.
interface sha_work_ctrl_if;

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] midState;
    logic [511:0] headData;
    logic         loadState;
    logic         solveEn;
    logic         flag;
    logic [31:0]  goldenNonce;

    modport master (
        input  rx_data, rx_valid, tx_ready, flag, goldenNonce,
        output tx_data, tx_valid, midState, headData, loadState, solveEn
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, flag, goldenNonce,
        input  tx_data, tx_valid, midState, headData, loadState, solveEn
    );

endinterface : sha_work_ctrl_if

// File: rtl/sha_resp_tx.sv
// Five-byte response serializer: status, nonce[31:24], [23:16], [15:8], [7:0].
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : one-cycle pulse; the response begins on the next cycle
//   status_i     : status byte (must be stable from the cycle after start_i)
//   nonce_i      : nonce to send (same stability as status_i)
//   tx_ready_i   : host accepts tx_data_o when tx_valid_o && tx_ready_i
//   tx_data_o    : current byte, 0 when idle
//   tx_valid_o   : byte valid
//   done_o       : high on the cycle the fifth byte is accepted
module sha_resp_tx
    import sha_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  status_i,
    input  logic [31:0] nonce_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       hs;
    logic [7:0] byte_sel;

    assign hs     = valid_q & tx_ready_i;
    assign done_o = hs && (idx_q == 3'(RESP_BYTES - 1));

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        if (start_i) begin
            valid_d = 1'b1;
            idx_d   = 3'd0;
        end else if (hs) begin
            if (idx_q == 3'(RESP_BYTES - 1)) begin
                valid_d = 1'b0;
                idx_d   = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0:    byte_sel = status_i;
            3'd1:    byte_sel = nonce_i[31:24];
            3'd2:    byte_sel = nonce_i[23:16];
            3'd3:    byte_sel = nonce_i[15:8];
            3'd4:    byte_sel = nonce_i[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    // Idle bus shows zero so the reset value of tx_data is well defined.
    assign tx_data_o  = valid_q ? byte_sel : 8'h00;
    assign tx_valid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule : sha_resp_tx

// File: rtl/sha_work_ctrl.sv
// SHA work controller: receives a 44-byte work unit from the host, builds
// the midstate and padded second header block, strobes them into the SHA
// core, enables solving, and returns a 5-byte result (status + nonce).
// Optional feature macro: SHA_TIMEOUT_EN -- adds a solve-cycle counter that
// aborts after TIMEOUT_CYCLES with status 8'h02 and nonce 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : sha_work_ctrl_if.master (host byte link + SHA core bus)
//   busy        : high whenever the FSM is not IDLE
//   dbg_state_o : current FSM state (sha_state_e encoding)
module sha_work_ctrl
    import sha_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES    = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    sha_work_ctrl_if.master    bus,
    output logic               busy,
    output logic [STATE_W-1:0] dbg_state_o
);

    sha_state_e   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] mid_q, mid_d;
    logic [95:0]  hw_q, hw_d;          // headData words 0..2
    logic [31:0]  load_cnt_q, load_cnt_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [7:0]   status_q, status_d;
    logic         resp_start;
    logic         resp_done;
`ifdef SHA_TIMEOUT_EN
    logic [31:0]  tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mid_d      = mid_q;
        hw_d       = hw_q;
        load_cnt_d = load_cnt_q;
        nonce_d    = nonce_q;
        status_d   = status_q;
        resp_start = 1'b0;
`ifdef SHA_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            // IDLE and RECV share the byte path: IDLE always sits at
            // count 0, so its first byte lands in byte slot 0.
            ST_IDLE, ST_RECV: begin
                if (bus.rx_valid) begin
                    for (int i = 0; i < 32; i++) begin
                        if (cnt_q == 6'(i)) mid_d[255 - 8*i -: 8] = bus.rx_data;
                    end
                    // Tail bytes are big-endian within each 32-bit word.
                    for (int i = 0; i < 12; i++) begin
                        if (cnt_q == 6'(32 + i)) hw_d[32*(i/4) + 8*(3 - i%4) +: 8] = bus.rx_data;
                    end
                    if (cnt_q == 6'(WORK_BYTES - 1)) begin
                        cnt_d      = 6'd0;
                        load_cnt_d = 32'd0;
                        state_d    = ST_LOAD;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = ST_RECV;
                    end
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == 32'(LOAD_CYCLES - 1)) begin
                    state_d = ST_SOLVE;
`ifdef SHA_TIMEOUT_EN
                    tmo_d   = 32'd0;
`endif
                end else begin
                    load_cnt_d = load_cnt_q + 32'd1;
                end
            end
            ST_SOLVE: begin
                // flag has priority over a timeout on the same cycle.
                if (bus.flag) begin
                    nonce_d    = bus.goldenNonce;
                    status_d   = STATUS_FOUND;
                    resp_start = 1'b1;
                    state_d    = ST_RESP;
                end
`ifdef SHA_TIMEOUT_EN
                // tmo_q counts completed SOLVE cycles; this is the last one.
                else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    nonce_d    = 32'd0;
                    status_d   = STATUS_TIMEOUT;
                    resp_start = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            mid_q      <= '0;
            hw_q       <= '0;
            load_cnt_q <= 32'd0;
            nonce_q    <= 32'd0;
            status_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mid_q      <= mid_d;
            hw_q       <= hw_d;
            load_cnt_q <= load_cnt_d;
            nonce_q    <= nonce_d;
            status_q   <= status_d;
        end
    end

`ifdef SHA_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= 32'd0;
        else     tmo_q <= tmo_d;
    end
`endif

    sha_resp_tx u_resp_tx (
        .clk        (clk),
        .rst        (rst),
        .start_i    (resp_start),
        .status_i   (status_q),
        .nonce_i    (nonce_q),
        .tx_ready_i (bus.tx_ready),
        .tx_data_o  (bus.tx_data),
        .tx_valid_o (bus.tx_valid),
        .done_o     (resp_done)
    );

    assign bus.midState  = mid_q;
    assign bus.headData  = {LEN_WORD15, 320'd0, PAD_WORD4, 32'd0, hw_q};
    assign bus.loadState = (state_q == ST_LOAD);
    assign bus.solveEn   = (state_q == ST_SOLVE);
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule : sha_work_ctrl

// File: doc/sha_work_ctrl.md
SHA_WORK_CTRL -- requirements
Module: sha_work_ctrl

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 2: number of cycles loadState is held high.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'hFFFF_FFFF: solve cycles before abort (used only under SHA_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  host work byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid this cycle; no backpressure.
REQ-007 SHALL have port tx_data  output  8  result byte to host.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid.
REQ-009 SHALL have port tx_ready  input  1  host accepts tx_data when tx_valid&&tx_ready.
REQ-010 SHALL have port midState  output  256  midstate to the SHA block.
REQ-011 SHALL have port headData  output  512  padded second header block to the SHA block.
REQ-012 SHALL have port loadState  output  1  load strobe to the SHA block.
REQ-013 SHALL have port solveEn  output  1  solve enable to the SHA block.
REQ-014 SHALL have port flag  input  1  SHA block found a golden nonce (level).
REQ-015 SHALL have port goldenNonce  input  32  nonce reported with flag.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> RECV -> LOAD -> SOLVE -> RESP -> IDLE.
REQ-018 IDLE: first rx_valid byte SHALL be stored as byte 0 and move to RECV.
REQ-019 RECV: SHALL accept exactly 44 bytes (counter 0..43); byte 43 moves to LOAD on the next edge.
REQ-020 Bytes 0..31 SHALL fill midState MSB first (byte 0 -> [255:248], byte 31 -> [7:0]).
REQ-021 Bytes 32..43 SHALL fill headData words 0..2 (word n = [32n+31:32n]), big-endian within the word (byte 32 -> [31:24]).
REQ-022 headData SHALL have constant padding: word3 = 0 (start nonce), word4 = 32'h80000000, words 5..14 = 0, word15 = 32'h00000280.
REQ-023 LOAD: loadState=1 and solveEn=0 for exactly LOAD_CYCLES cycles, then SOLVE.
REQ-024 SOLVE: solveEn=1 and loadState=0; first cycle with flag=1 SHALL capture goldenNonce, set status 8'h01, and go to RESP.
REQ-025 RESP: SHALL send 5 bytes: status, then nonce [31:24], [23:16], [15:8], [7:0]; each byte held until tx_ready; IDLE after the 5th handshake.
REQ-026 tx_valid SHALL be 0 outside RESP; solveEn SHALL be 0 in RESP.
REQ-027 rx_valid SHALL be ignored in LOAD, SOLVE and RESP; such bytes are dropped.
REQ-028 midState/headData SHALL stay stable from LOAD entry until return to IDLE.

Reset
REQ-029 rst SHALL asynchronously force IDLE, byte counter 0, midState 0, headData words 0..2 = 0, loadState 0, solveEn 0, tx_valid 0, tx_data 0, busy 0, captured nonce 0.
REQ-030 rst asserted mid-RECV/SOLVE/RESP SHALL discard partial work; no response byte after release.

Configuration
REQ-031 With SHA_TIMEOUT_EN defined, a 32-bit counter SHALL clear on SOLVE entry and count SOLVE cycles.
REQ-032 When the counter reaches TIMEOUT_CYCLES with flag=0, the block SHALL go to RESP with status 8'h02 and nonce 0.
REQ-033 If flag=1 on the timeout cycle, flag SHALL win (status 8'h01).
REQ-034 Without SHA_TIMEOUT_EN, SOLVE SHALL exit only on flag, and no counter SHALL be synthesised.

Structure
REQ-035 Package sha_pkg SHALL hold the state enum, STATUS_FOUND=8'h01, STATUS_TIMEOUT=8'h02, WORK_BYTES=44, PAD_WORD4=32'h80000000, LEN_WORD15=32'h00000280.
REQ-036 Sub-module sha_resp_tx SHALL implement the 5-byte RESP serializer with the tx handshake.

Verification
REQ-037 Send 32 midstate bytes 28 30 48 99 ... dc and tail bytes 7d ab 00 c4 76 16 7e 54 61 48 1b 18 -> midState=256'h28304899...1e397ddc, word0=7dab00c4, word2=61481b18, word4=80000000, word15=00000280, loadState high for 2 cycles, then solveEn=1.
REQ-038 In SOLVE, drive flag=1 with goldenNonce=32'h0E33337A; tx_ready=1 -> tx bytes 01 0E 33 33 7A, then busy=0.
REQ-039 In RESP, hold tx_ready=0 for 3 cycles -> tx_data/tx_valid stable; no byte skipped.
REQ-040 Assert rst after rx byte 20, then send 44 fresh bytes -> only the fresh work is loaded.
REQ-041 With SHA_TIMEOUT_EN and TIMEOUT_CYCLES=100, keep flag=0 -> at SOLVE cycle 100, tx bytes 02 00 00 00 00.
REQ-042 Drive rx_valid bytes during SOLVE -> midState/headData unchanged; response still correct.
